// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StWrite,
    StCheck,
    StRun,
    StError
  } state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrBadLen   = 2'd1,
    ErrChecksum = 2'd2,
    ErrTimeout  = 2'd3
  } err_code_e;

  // Multi-byte fields (length and instruction words) arrive most-significant byte first.
  localparam int unsigned HiByteLsb = 8;
  localparam int unsigned LoByteLsb = 0;

  function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_data;
  logic              mem_write_enable;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data, mem_write_enable
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data, mem_write_enable
  );
endinterface

// File: rtl/loader_idle_timer.sv
// Counts idle cycles while enabled; expired fires on the TIMEOUT-th consecutive idle cycle.
module loader_idle_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // An accepted byte in the same cycle wins over expiry.
  assign expired = enable && !clear && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a checksummed byte frame into 16-bit instruction-memory writes and
// holds the CPU in reset until a frame has been accepted.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus,
  input  logic            reload,
  output logic            cpu_reset,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code
);

  state_e      state_q, state_d;
  err_code_e   err_q, err_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] data_q, data_d;

  logic        accept;
  logic        timer_en;
  logic        timer_expired;
  logic        last_word;
  logic [15:0] len_word;

  assign bus.rx_ready = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign timer_en     = state_q inside {StLenLo, StDataHi, StDataLo, StCheck};
  assign len_word     = be_word(len_hi_q, bus.rx_data);
  // Index is wider than the address so word 4095 compares correctly against N-1.
  assign last_word    = (idx_q == (len_q - 16'd1));

  loader_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .clear  (accept),
    .expired(timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    len_hi_d = len_hi_q;
    xor_d    = xor_q;
    len_d    = len_q;
    idx_d    = idx_q;
    data_d   = data_q;

    if (accept) begin
      xor_d = xor_q ^ bus.rx_data;
    end

    unique case (state_q)
      StLenHi: begin
        if (accept) begin
          len_hi_d = bus.rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_word;
          if ({16'd0, len_word} > DEPTH) begin
            state_d = StError;
            err_d   = ErrBadLen;
          end else if (len_word == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) begin
          data_d[HiByteLsb +: 8] = bus.rx_data;
          state_d                = StDataLo;
        end
      end
      StDataLo: begin
        if (accept) begin
          data_d[LoByteLsb +: 8] = bus.rx_data;
          state_d                = StWrite;
        end
      end
      StWrite: begin
        idx_d   = idx_q + 16'd1;
        state_d = last_word ? StCheck : StDataHi;
      end
      StCheck: begin
        if (accept) begin
          if ((xor_q ^ bus.rx_data) == 8'h00) begin
            state_d = StRun;
          end else begin
            state_d = StError;
            err_d   = ErrChecksum;
          end
        end
      end
      StRun, StError: begin
        if (reload) begin
          state_d = StLenHi;
          err_d   = ErrNone;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      default: state_d = StLenHi;
    endcase

    // Only asserted in the in-frame states and never alongside an accepted byte.
    if (timer_expired) begin
      state_d = StError;
      err_d   = ErrTimeout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StLenHi;
      err_q    <= ErrNone;
      len_hi_q <= '0;
      xor_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      len_hi_q <= len_hi_d;
      xor_q    <= xor_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign bus.mem_address      = idx_q[ADDR_W-1:0];
  assign bus.mem_data         = data_q;
  assign bus.mem_write_enable = (state_q == StWrite);
  assign cpu_reset            = (state_q != StRun);
  assign done                 = (state_q == StRun);
  assign error                = (state_q == StError);
  assign err_code             = err_q;

endmodule
